dm_wb_cache_ctrl: RTL

Parametrised direct-mapped write-back cache controller. It is the successor to the fixed 32-bit `cache_controller_if` controller and adds configurable address width, data width and line count. It also adds dirty tracking with victim write-back, a `mem_ready` memory handshake, and a flush that writes back every dirty line. It sits between the CPU-side request port and the memory-side port.

---
 rtl/dm_cache_pkg.sv | 19 +
 rtl/dm_cache_array.sv | 87 ++++++++
 rtl/dm_wb_cache_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_pkg
// Brief    : Shared types for the direct-mapped write-back cache controller.
// Revision : 1.0 - initial release
// ============================================================================
package dm_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COMPARE    = 3'd1,
        ST_WRITEBACK  = 3'd2,
        ST_FETCH      = 3'd3,
        ST_FLUSH_SCAN = 3'd4,
        ST_FLUSH_WB   = 3'd5
    } cache_state_e;

endpackage
`default_nettype wire

// File: rtl/dm_cache_array.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_array
// Brief    : Per-line tag/valid/dirty/data storage with one combinational read
//            port, one write port and a per-line clear used by flush.
// Revision : 1.0 - initial release
// ============================================================================
module dm_cache_array #(
    parameter int LINES  = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 28,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_dirty,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  clr_idx
);

    logic [LINES-1:0] valid_vec;
    logic [LINES-1:0] dirty_vec;
    logic [TAG_W-1:0]  tag_vec  [LINES];
    logic [DATA_W-1:0] data_vec [LINES];

    for (genvar i = 0; i < LINES; i++) begin : g_line
        logic              valid_d, valid_q;
        logic              dirty_d, dirty_q;
        logic [TAG_W-1:0]  tag_d, tag_q;
        logic [DATA_W-1:0] data_d, data_q;

        // A write installs the line as valid; a clear drops valid and dirty.
        always_comb begin
            valid_d = valid_q;
            dirty_d = dirty_q;
            tag_d   = tag_q;
            data_d  = data_q;
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                valid_d = 1'b1;
                dirty_d = wr_dirty;
                tag_d   = wr_tag;
                data_d  = wr_data;
            end else if (clr_en && (clr_idx == IDX_W'(i))) begin
                valid_d = 1'b0;
                dirty_d = 1'b0;
            end
        end

        // Status bits are reset; an invalid line's tag/data are don't-care.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_q <= 1'b0;
                dirty_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
                dirty_q <= dirty_d;
            end
        end

        // Payload storage without reset.
        always_ff @(posedge clk) begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end

        assign valid_vec[i] = valid_q;
        assign dirty_vec[i] = dirty_q;
        assign tag_vec[i]   = tag_q;
        assign data_vec[i]  = data_q;
    end

    assign rd_valid = valid_vec[rd_idx];
    assign rd_dirty = dirty_vec[rd_idx];
    assign rd_tag   = tag_vec[rd_idx];
    assign rd_data  = data_vec[rd_idx];

endmodule
`default_nettype wire

// File: rtl/dm_wb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_wb_cache_ctrl
// Brief    : Parametrised direct-mapped write-back cache controller with
//            victim write-back, mem_ready handshake and full flush.
// Revision : 1.0 - initial release
// ============================================================================
module dm_wb_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic              flush,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              hit,
    output logic              miss,
    output logic              ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    cache_state_e      state_d, state_q;
    logic              is_wr_d, is_wr_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic [DATA_W-1:0] read_data_d, read_data_q;
    logic [IDX_W-1:0]  fidx_d, fidx_q;

    logic              arr_valid, arr_dirty;
    logic [TAG_W-1:0]  arr_tag;
    logic [DATA_W-1:0] arr_data;
    logic [IDX_W-1:0]  arr_idx;
    logic              wr_en, wr_dirty, clr_en;
    logic [DATA_W-1:0] wr_data;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              in_flush, lookup_hit, last_line;

    assign req_idx    = addr_q[IDX_W-1:0];
    assign req_tag    = addr_q[ADDR_W-1:IDX_W];
    assign in_flush   = (state_q == ST_FLUSH_SCAN) || (state_q == ST_FLUSH_WB);
    assign arr_idx    = in_flush ? fidx_q : req_idx;
    assign lookup_hit = arr_valid && (arr_tag == req_tag);
    assign last_line  = (fidx_q == IDX_W'(LINES - 1));
    assign ready      = (state_q == ST_IDLE);
    assign read_data  = read_data_q;

    dm_cache_array #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (arr_idx),
        .rd_valid (arr_valid),
        .rd_dirty (arr_dirty),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .wr_en    (wr_en),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_data  (wr_data),
        .wr_dirty (wr_dirty),
        .clr_en   (clr_en),
        .clr_idx  (fidx_q)
    );

    // Next-state, array control and port outputs.
    always_comb begin
        state_d        = state_q;
        is_wr_d        = is_wr_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        read_data_d    = read_data_q;
        fidx_d         = fidx_q;
        hit            = 1'b0;
        miss           = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        wr_en          = 1'b0;
        wr_data        = wdata_q;
        wr_dirty       = 1'b1;
        clr_en         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    fidx_d  = '0;
                    state_d = ST_FLUSH_SCAN;
                end else if (write || read) begin
                    is_wr_d = write;
                    addr_d  = address;
                    wdata_d = write_data;
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (lookup_hit) begin
                    hit     = 1'b1;
                    state_d = ST_IDLE;
                    if (is_wr_q) begin
                        wr_en = 1'b1;
                    end else begin
                        read_data_d = arr_data;
                    end
                end else begin
                    miss = 1'b1;
                    if (arr_valid && arr_dirty) begin
                        state_d = ST_WRITEBACK;
                    end else if (is_wr_q) begin
                        // One-word lines: write-allocate needs no fill.
                        wr_en   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WRITEBACK: begin
                mem_write      = 1'b1;
                mem_address    = {arr_tag, req_idx};
                mem_write_data = arr_data;
                if (mem_ready) begin
                    if (is_wr_q) begin
                        wr_en   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                mem_read    = 1'b1;
                mem_address = addr_q;
                if (mem_ready) begin
                    wr_en       = 1'b1;
                    wr_dirty    = 1'b0;
                    wr_data     = mem_read_data;
                    read_data_d = mem_read_data;
                    state_d     = ST_IDLE;
                end
            end
            ST_FLUSH_SCAN: begin
                if (arr_valid && arr_dirty) begin
                    state_d = ST_FLUSH_WB;
                end else begin
                    clr_en = 1'b1;
                    if (last_line) begin
                        state_d = ST_IDLE;
                    end else begin
                        fidx_d = fidx_q + IDX_W'(1);
                    end
                end
            end
            ST_FLUSH_WB: begin
                mem_write      = 1'b1;
                mem_address    = {arr_tag, fidx_q};
                mem_write_data = arr_data;
                if (mem_ready) begin
                    clr_en = 1'b1;
                    if (last_line) begin
                        state_d = ST_IDLE;
                    end else begin
                        fidx_d  = fidx_q + IDX_W'(1);
                        state_d = ST_FLUSH_SCAN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers; reset returns to IDLE and abandons any beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            fidx_q      <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            fidx_q      <= fidx_d;
        end
    end

endmodule
`default_nettype wire
